// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel scan sequencer
package sobel_pkg;

  localparam int DIM_W   = 12;
  localparam int MIN_DIM = 3;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    LOAD,
    FETCH,
    CALC,
    WRITE,
    MOVE,
    DONE,
    ERROR
  } seq_state_t;

  // States that wait on an external unit and are therefore watched by the timer
  function automatic logic is_waiting(input seq_state_t s);
    return (s inside {LOAD, FETCH, CALC, WRITE, MOVE});
  endfunction

  function automatic logic is_busy(input seq_state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - per-state handshake timer, flags expiry after TIMEOUT cycles
module seq_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;

  assign expired = (count_q == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_scan_sequencer.sv
// rtl/sobel_scan_sequencer.sv - frame-level sequencer: load, then fetch/calc/write/move per window
module sobel_scan_sequencer #(
  parameter int DIM_W   = sobel_pkg::DIM_W,
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_length,
  input  logic             load_done,
  input  logic             move_done,
  input  logic             all_done,
  input  logic             fetch_done,
  input  logic             calc_done,
  input  logic             wr_done,
  output logic             load_initial,
  output logic             start_move,
  output logic             fetch_req,
  output logic             fetch_full,
  output logic             calc_start,
  output logic             wr_req,
  output logic             busy,
  output logic             frame_done,
  output logic             error,
  output logic [CNT_W-1:0] pix_count
);

  import sobel_pkg::*;

  seq_state_t       state_q, state_d;
  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] length_q, length_d;
  logic             first_win_q, first_win_d;
  logic [CNT_W-1:0] pix_count_d;

  logic load_initial_d, start_move_d, fetch_req_d, fetch_full_d;
  logic calc_start_d, wr_req_d, busy_d, frame_done_d, error_d;

  logic wd_clear, wd_enable, wd_expired;

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .n_reset(n_reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    length_d    = length_q;
    first_win_d = first_win_q;
    pix_count_d = pix_count;

    if (is_waiting(state_q) && wd_expired) begin
      state_d = ERROR;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_d     = CHECK;
            width_d     = img_width;
            length_d    = img_length;
            pix_count_d = '0;
          end
        end
        CHECK: begin
          if ((width_q < DIM_W'(MIN_DIM)) || (length_q < DIM_W'(MIN_DIM))) begin
            state_d = ERROR;
          end else begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (load_done) begin
            state_d     = FETCH;
            first_win_d = 1'b1;
          end
        end
        FETCH: begin
          if (fetch_done) begin
            state_d     = CALC;
            first_win_d = 1'b0;
          end
        end
        CALC: begin
          if (calc_done) begin
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (wr_done) begin
            state_d = MOVE;
            if (pix_count != '1) begin
              pix_count_d = pix_count + 1'b1;
            end
          end
        end
        MOVE: begin
          // A scan-exhausted mover takes priority over a simultaneous step-done
          if (all_done) begin
            state_d = DONE;
          end else if (move_done) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    wd_clear  = (state_d != state_q);
    wd_enable = is_waiting(state_q);

    // Outputs are decoded from the next state so they register alongside it
    load_initial_d = (state_d == LOAD);
    fetch_req_d    = (state_d == FETCH);
    fetch_full_d   = (state_d == FETCH) && first_win_d;
    calc_start_d   = (state_d == CALC) && (state_q != CALC);
    wr_req_d       = (state_d == WRITE);
    start_move_d   = (state_d == MOVE);
    busy_d         = is_busy(state_d);
    frame_done_d   = (state_d == DONE) && (state_q != DONE);
    error_d        = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      width_q      <= '0;
      length_q     <= '0;
      first_win_q  <= 1'b0;
      pix_count    <= '0;
      load_initial <= 1'b0;
      start_move   <= 1'b0;
      fetch_req    <= 1'b0;
      fetch_full   <= 1'b0;
      calc_start   <= 1'b0;
      wr_req       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      length_q     <= length_d;
      first_win_q  <= first_win_d;
      pix_count    <= pix_count_d;
      load_initial <= load_initial_d;
      start_move   <= start_move_d;
      fetch_req    <= fetch_req_d;
      fetch_full   <= fetch_full_d;
      calc_start   <= calc_start_d;
      wr_req       <= wr_req_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      error        <= error_d;
    end
  end

endmodule

// File: tb/tb_sobel_scan_sequencer.sv
// tb/tb_sobel_scan_sequencer.sv - randomized responders and frame-level model for the sequencer
module tb_sobel_scan_sequencer;

  localparam int DIM_W = 12;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             n_reset;
  logic             start;
  logic [DIM_W-1:0] img_width, img_length;
  logic             load_done, move_done, all_done, fetch_done, calc_done, wr_done;
  logic             load_initial, start_move, fetch_req, fetch_full, calc_start, wr_req;
  logic             busy, frame_done, error;
  logic [CNT_W-1:0] pix_count;

  sobel_scan_sequencer #(
    .DIM_W  (DIM_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .img_width   (img_width),
    .img_length  (img_length),
    .load_done   (load_done),
    .move_done   (move_done),
    .all_done    (all_done),
    .fetch_done  (fetch_done),
    .calc_done   (calc_done),
    .wr_done     (wr_done),
    .load_initial(load_initial),
    .start_move  (start_move),
    .fetch_req   (fetch_req),
    .fetch_full  (fetch_full),
    .calc_start  (calc_start),
    .wr_req      (wr_req),
    .busy        (busy),
    .frame_done  (frame_done),
    .error       (error),
    .pix_count   (pix_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int fixed_dly = -1;
  int l_cnt = 0, f_cnt = 0, c_cnt = 0, w_cnt = 0, m_cnt = 0;
  int l_dly = 0, f_dly = 0, c_dly = 0, w_dly = 0, m_dly = 0;
  bit c_pend = 0;
  bit suppress_calc = 0;
  bit both_mode = 0;
  int windows = 0;
  int writes_seen = 0;

  int n_fetch = 0, n_full = 0, n_frame_done = 0;
  bit first_full = 0;
  bit prev_fetch = 0;
  bit saw_load = 0, saw_fetch = 0, saw_wr = 0;
  bit mono_bad = 0;
  longint prev_pix = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pick_dly();
    return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
  endfunction

  // One clock: sample outputs after the edge, then drive responder inputs for the next edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (fetch_req && !prev_fetch) begin
      n_fetch++;
      if (fetch_full) n_full++;
      if (n_fetch == 1) first_full = fetch_full;
    end
    prev_fetch = fetch_req;
    if (frame_done) n_frame_done++;
    if (load_initial) saw_load = 1;
    if (fetch_req) saw_fetch = 1;
    if (wr_req) saw_wr = 1;
    if (longint'(pix_count) < prev_pix) mono_bad = 1;
    prev_pix = longint'(pix_count);

    load_done = 0; fetch_done = 0; calc_done = 0;
    wr_done = 0; move_done = 0; all_done = 0;

    if (load_initial) begin
      if (l_cnt == l_dly) load_done = 1;
      l_cnt++;
    end else begin
      l_cnt = 0; l_dly = pick_dly();
    end

    if (fetch_req) begin
      if (f_cnt == f_dly) fetch_done = 1;
      f_cnt++;
    end else begin
      f_cnt = 0; f_dly = pick_dly();
      if ($urandom_range(0, 7) == 0) fetch_done = 1;
    end

    if (calc_start) begin
      c_cnt = 0; c_pend = !suppress_calc; c_dly = pick_dly();
    end
    if (c_pend) begin
      if (c_cnt == c_dly) begin
        calc_done = 1; c_pend = 0;
      end
      c_cnt++;
    end

    if (wr_req) begin
      if (w_cnt == w_dly) begin
        wr_done = 1; writes_seen++;
      end
      w_cnt++;
    end else begin
      w_cnt = 0; w_dly = pick_dly();
      if ($urandom_range(0, 7) == 0) wr_done = 1;
    end

    if (start_move) begin
      if (m_cnt == m_dly) begin
        if (writes_seen >= windows) begin
          all_done = 1; move_done = both_mode;
        end else begin
          move_done = 1;
        end
      end
      m_cnt++;
    end else begin
      m_cnt = 0; m_dly = pick_dly();
    end
  endtask

  task automatic pulse_start(input int w, input int l);
    img_width = DIM_W'(w); img_length = DIM_W'(l);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_frame(input string tag, input int w, input int l, input bit both, input int restart_at);
    int exp_pix;
    int t;
    bit restarted;
    exp_pix = 0;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < l; c++)
        if (r > 0 && r < w - 1 && c > 0 && c < l - 1) exp_pix++;
    windows = exp_pix; writes_seen = 0; both_mode = both;
    n_fetch = 0; n_full = 0; n_frame_done = 0; first_full = 0;
    mono_bad = 0; prev_pix = 0; restarted = 0;
    pulse_start(w, l);
    t = 0;
    while (!frame_done && !error && t < 5000) begin
      if (restart_at > 0 && !restarted && int'(pix_count) == restart_at) begin
        pulse_start(3, 3);
        restarted = 1;
      end else begin
        tick();
      end
      t++;
    end
    repeat (6) tick();
    check({tag, "_error"}, error, 0);
    check({tag, "_frame_done_pulses"}, n_frame_done, 1);
    check({tag, "_pix_count"}, pix_count, exp_pix);
    check({tag, "_windows_fetched"}, n_fetch, exp_pix);
    check({tag, "_full_fetches"}, n_full, 1);
    check({tag, "_first_fetch_full"}, first_full, 1);
    check({tag, "_pix_monotonic"}, mono_bad, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_fetch_idle_after"}, fetch_req, 0);
  endtask

  initial begin
    int t;
    int t_calc;
    n_reset = 0; start = 0; img_width = '0; img_length = '0;
    load_done = 0; move_done = 0; all_done = 0;
    fetch_done = 0; calc_done = 0; wr_done = 0;

    repeat (3) tick();
    check("rst_outputs", {load_initial, start_move, fetch_req, fetch_full, calc_start,
                          wr_req, busy, frame_done, error}, 0);
    check("rst_pix_count", pix_count, 0);
    n_reset = 1;
    tick();

    fixed_dly = 2;
    run_frame("f4x4", 4, 4, 0, 0);
    fixed_dly = -1;

    saw_load = 0; saw_fetch = 0;
    pulse_start(2, 8);
    check("dim_check_busy", busy, 1);
    check("dim_check_error_early", error, 0);
    tick();
    check("dim_error", error, 1);
    check("dim_error_busy", busy, 0);
    repeat (4) tick();
    check("dim_error_sticky", error, 1);
    check("dim_no_load", saw_load, 0);
    check("dim_no_fetch", saw_fetch, 0);

    suppress_calc = 1; saw_wr = 0; windows = 4; writes_seen = 0;
    t_calc = -1;
    pulse_start(4, 4);
    check("to_error_cleared", error, 0);
    t = 0;
    while (!error && t < 300) begin
      tick();
      if (calc_start && t_calc < 0) t_calc = cyc;
      t++;
    end
    check("to_error", error, 1);
    check("to_latency", cyc - t_calc, 16);
    check("to_no_wr_req", saw_wr, 0);
    check("to_requests_dropped", {load_initial, start_move, fetch_req, calc_start, wr_req, busy}, 0);
    suppress_calc = 0; c_pend = 0;

    run_frame("restart_ignored", 5, 4, 0, 2);
    run_frame("both_done", 4, 5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      run_frame($sformatf("rnd%0d", i), int'($urandom_range(3, 6)), int'($urandom_range(3, 6)),
                1'($urandom_range(0, 1)), 0);
    end

    windows = 9; writes_seen = 0;
    pulse_start(5, 5);
    t = 0;
    while (!(wr_req && pix_count >= 1) && t < 2000) begin
      tick();
      t++;
    end
    check("rst_mid_reached_write", wr_req, 1);
    n_reset = 0;
    #2;
    check("rst_mid_outputs", {load_initial, start_move, fetch_req, fetch_full, calc_start,
                              wr_req, busy, frame_done, error}, 0);
    check("rst_mid_pix_count", pix_count, 0);
    c_pend = 0;
    repeat (2) tick();
    n_reset = 1;
    tick();
    run_frame("after_rst_5x5", 5, 5, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
